ps2_keystream_decoder: RTL
==========================

// Module: ps2_keystream_decoder
// PURPOSE
//  Stateful PS/2 set-2 scan-code to ASCII decoder. Consumes raw bytes from the PS/2 receiver;
//  tracks E0/F0 prefixes, Shift and Caps Lock; emits upper/lower-case ASCII into a FIFO.
//  Drains through a valid/ready port to the terminal/UART front end. Break codes never emit.
// PARAMETERS
//  FIFO_DEPTH     8   output FIFO entries; power of two, >= 2
//  SHIFT_SYMBOLS  1   1: Shift+digit row gives !@#$%^&*() and Shift+'-'/'=' give '_'/'+'
//                     0: Shift affects letters only
// PORTS
//  clk            in   1  system clock
//  rst            in   1  synchronous, active-high reset
//  code_in        in   8  scan-code byte from PS/2 receiver
//  code_valid     in   1  one-cycle strobe, code_in valid
//  ascii_out      out  8  FIFO head character; 8'h00 when empty
//  ascii_valid    out  1  FIFO not empty
//  ascii_ready    in   1  consumer accepts head when ascii_valid & ascii_ready
//  shift_active   out  1  Left or Right Shift held
//  caps_active    out  1  Caps Lock latched on
//  overflow       out  1  sticky: a character was dropped on a full FIFO
// BEHAVIOUR
//  Reset (clk edge with rst=1): all outputs 0, FIFO empty, state IDLE, modifiers cleared.
//  Reset mid-sequence discards any pending prefix and all queued characters.
//  Prefix FSM, advances only on code_valid:
//   IDLE:  E0->EXT, F0->BRK, else make(code, ext=0), stay IDLE
//   EXT:   F0->EXT_BRK, else make(code, ext=1) -> IDLE
//   BRK:   break(code, ext=0) -> IDLE;  EXT_BRK: break(code, ext=1) -> IDLE
//   Bytes AA/FA/EE/FE in any state: ignored, state -> IDLE, no emission.
//  make(): 12/59 set lshift/rshift; 58 toggles caps only if caps_held=0, then caps_held=1;
//   otherwise LUT lookup; nonzero result is pushed. break(): 12/59 clear shift bit;
//   58 clears caps_held; all others no effect.
//  Case: letters uppercase iff shift_active XOR caps_active; else 8'h61-8'h7A.
//  LUT (ext=0): main + keypad digits 8'h30-39, 4E/7B '-', 55 '=', 7C '*', 79 '+',
//   29 space 8'h20, 5A Enter 8'h0A, 66 Backspace 8'h08. ext=1: 4A '/', 5A 8'h0A;
//   every other extended code and every unmapped code -> 8'h00 (no push).
//  Keypad keys are never shifted. Typematic repeat makes emit again (one char per make).
//  Latency: code_valid at edge N -> char in FIFO, ascii_valid=1 after edge N.
//  FIFO: push and pop in same cycle always legal; when full, push succeeds only if pop
//   occurs same cycle, otherwise char dropped and overflow set (clears only on rst).
//  Empty: ascii_valid=0, ascii_out=8'h00, ascii_ready ignored.
//  Pointers are log2(FIFO_DEPTH)+1 bits; full/empty from MSB compare, wrap naturally.
// STRUCTURE
//  Shared header ps2_defs.vh: scan-code constants (PS2_EXT=E0, PS2_BRK=F0, LSHIFT, RSHIFT,
//   CAPS, ENTER, BKSP, KP_*) and ASCII constants (NUL, LF, BS, SPACE).
//  Sub-module ps2_scan_lut: combinational {code, ext, upper, shift} -> ascii[7:0].
//  Top holds prefix FSM, modifier regs, FIFO (register array + pointers).
// TESTING
//  1C -> 'a' 8'h61; 12,1C,F0,1C,F0,12,1C -> 8'h41 then 8'h61; shift_active 1 then 0.
//  58,F0,58,1C,58,58,F0,58,1C -> 8'h41,8'h61 (held-repeat 58 does not retoggle caps).
//  E0,4A -> 8'h2F; E0,5A -> 8'h0A; E0,F0,4A -> nothing; 12,70 -> 8'h30 (keypad unshifted).
//  SHIFT_SYMBOLS=1: 12,16 -> 8'h21; SHIFT_SYMBOLS=0: 12,16 -> 8'h31.
//  ascii_ready=0, feed FIFO_DEPTH+1 makes -> first DEPTH chars kept in order, overflow=1;
//   full+push+pop same cycle -> no drop.
//  Send E0 then rst, then 5A -> 8'h0A via non-extended path; FIFO empty and overflow=0 post-rst.

Source files
------------

// File: rtl/ps2_keystream_decoder_pkg.sv
// ps2_keystream_decoder_pkg: scan-code/ASCII constants and prefix-state type shared by the decoder files
package ps2_keystream_decoder_pkg;
  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;
  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] LSHIFT    = 8'h12;
  localparam logic [7:0] RSHIFT    = 8'h59;
  localparam logic [7:0] CAPS      = 8'h58;
  localparam logic [7:0] ENTER     = 8'h5A;
  localparam logic [7:0] BKSP      = 8'h66;
  localparam logic [7:0] SPACE_KEY = 8'h29;
  localparam logic [7:0] KP_SLASH  = 8'h4A;
  localparam logic [7:0] KP_MINUS  = 8'h7B;
  localparam logic [7:0] KP_STAR   = 8'h7C;
  localparam logic [7:0] KP_PLUS   = 8'h79;
  localparam logic [7:0] NUL       = 8'h00;
  localparam logic [7:0] LF        = 8'h0A;
  localparam logic [7:0] BS        = 8'h08;
  localparam logic [7:0] SPACE     = 8'h20;
  // Keyboard self-test/ack/echo/resend bytes carry no key information.
  function automatic logic is_ignored(input logic [7:0] c);
    return c == 8'hAA || c == 8'hFA || c == 8'hEE || c == 8'hFE;
  endfunction
endpackage

// File: rtl/ps2_scan_lut.sv
// ps2_scan_lut: combinational set-2 scan code to ASCII lookup
// Ports: code/ext select the key, upper selects letter case, shift selects digit-row symbols;
// ascii is 8'h00 for any code that produces no character.
module ps2_scan_lut
  import ps2_keystream_decoder_pkg::*;
#(
  parameter int SHIFT_SYMBOLS = 1
) (
  input  logic [7:0] code,
  input  logic       ext,
  input  logic       upper,
  input  logic       shift,
  output logic [7:0] ascii
);
  logic [7:0] lo, hi;
  logic       letter;
  always_comb begin
    lo = NUL;
    hi = NUL;
    case (code)
      8'h1C: lo = 8'h61;
      8'h32: lo = 8'h62;
      8'h21: lo = 8'h63;
      8'h23: lo = 8'h64;
      8'h24: lo = 8'h65;
      8'h2B: lo = 8'h66;
      8'h34: lo = 8'h67;
      8'h33: lo = 8'h68;
      8'h43: lo = 8'h69;
      8'h3B: lo = 8'h6A;
      8'h42: lo = 8'h6B;
      8'h4B: lo = 8'h6C;
      8'h3A: lo = 8'h6D;
      8'h31: lo = 8'h6E;
      8'h44: lo = 8'h6F;
      8'h4D: lo = 8'h70;
      8'h15: lo = 8'h71;
      8'h2D: lo = 8'h72;
      8'h1B: lo = 8'h73;
      8'h2C: lo = 8'h74;
      8'h3C: lo = 8'h75;
      8'h2A: lo = 8'h76;
      8'h1D: lo = 8'h77;
      8'h22: lo = 8'h78;
      8'h35: lo = 8'h79;
      8'h1A: lo = 8'h7A;
      8'h45: begin lo = 8'h30; hi = 8'h29; end
      8'h16: begin lo = 8'h31; hi = 8'h21; end
      8'h1E: begin lo = 8'h32; hi = 8'h40; end
      8'h26: begin lo = 8'h33; hi = 8'h23; end
      8'h25: begin lo = 8'h34; hi = 8'h24; end
      8'h2E: begin lo = 8'h35; hi = 8'h25; end
      8'h36: begin lo = 8'h36; hi = 8'h5E; end
      8'h3D: begin lo = 8'h37; hi = 8'h26; end
      8'h3E: begin lo = 8'h38; hi = 8'h2A; end
      8'h46: begin lo = 8'h39; hi = 8'h28; end
      8'h4E: begin lo = 8'h2D; hi = 8'h5F; end
      8'h55: begin lo = 8'h3D; hi = 8'h2B; end
      8'h70: lo = 8'h30;
      8'h69: lo = 8'h31;
      8'h72: lo = 8'h32;
      8'h7A: lo = 8'h33;
      8'h6B: lo = 8'h34;
      8'h73: lo = 8'h35;
      8'h74: lo = 8'h36;
      8'h6C: lo = 8'h37;
      8'h75: lo = 8'h38;
      8'h7D: lo = 8'h39;
      KP_MINUS:  lo = 8'h2D;
      KP_STAR:   lo = 8'h2A;
      KP_PLUS:   lo = 8'h2B;
      SPACE_KEY: lo = SPACE;
      ENTER:     lo = LF;
      BKSP:      lo = BS;
      default: ;
    endcase
    letter = lo >= 8'h61 && lo <= 8'h7A;
    ascii = ext ? (code == KP_SLASH ? 8'h2F : code == ENTER ? LF : NUL)
          : letter ? (upper ? lo - 8'h20 : lo)
          : (SHIFT_SYMBOLS != 0 && shift && hi != NUL) ? hi : lo;
  end
endmodule

// File: rtl/ps2_keystream_decoder.sv
// ps2_keystream_decoder: PS/2 set-2 byte stream to ASCII with prefix FSM, modifiers and output FIFO
// Ports: code_in/code_valid from the PS/2 receiver; ascii_out/ascii_valid/ascii_ready drain the FIFO;
// shift_active/caps_active mirror modifier state; overflow is sticky after a dropped character.
module ps2_keystream_decoder
  import ps2_keystream_decoder_pkg::*;
#(
  parameter int FIFO_DEPTH    = 8,
  parameter int SHIFT_SYMBOLS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] code_in,
  input  logic       code_valid,
  output logic [7:0] ascii_out,
  output logic       ascii_valid,
  input  logic       ascii_ready,
  output logic       shift_active,
  output logic       caps_active,
  output logic       overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  state_t state, state_nx;
  logic do_make, do_break, ext;
  logic lshift, rshift, caps, caps_held;
  logic [7:0] lut_ascii;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW:0] wptr, rptr;
  logic empty, full, push, pop, push_ok;
  always_comb begin
    state_nx = state;
    do_make = 1'b0;
    do_break = 1'b0;
    ext = state == EXT || state == EXT_BRK;
    if (code_valid) begin
      if (is_ignored(code_in)) state_nx = IDLE;
      else if (state == IDLE && code_in == PS2_EXT) state_nx = EXT;
      else if ((state == IDLE || state == EXT) && code_in == PS2_BRK) state_nx = state == IDLE ? BRK : EXT_BRK;
      else begin
        state_nx = IDLE;
        do_make = state == IDLE || state == EXT;
        do_break = state == BRK || state == EXT_BRK;
      end
    end
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  // caps_held suppresses re-toggling while Caps Lock typematic-repeats.
  always_ff @(posedge clk) begin
    if (rst) begin
      lshift <= 1'b0;
      rshift <= 1'b0;
      caps <= 1'b0;
      caps_held <= 1'b0;
    end else if (do_make) begin
      if (code_in == LSHIFT) lshift <= 1'b1;
      if (code_in == RSHIFT) rshift <= 1'b1;
      if (code_in == CAPS) begin
        if (!caps_held) caps <= ~caps;
        caps_held <= 1'b1;
      end
    end else if (do_break) begin
      if (code_in == LSHIFT) lshift <= 1'b0;
      if (code_in == RSHIFT) rshift <= 1'b0;
      if (code_in == CAPS) caps_held <= 1'b0;
    end
  end
  assign shift_active = lshift | rshift;
  assign caps_active = caps;
  ps2_scan_lut #(.SHIFT_SYMBOLS(SHIFT_SYMBOLS)) u_lut (
    .code (code_in),
    .ext  (ext),
    .upper(shift_active ^ caps),
    .shift(shift_active),
    .ascii(lut_ascii)
  );
  assign empty = wptr == rptr;
  assign full = wptr[AW] != rptr[AW] && wptr[AW-1:0] == rptr[AW-1:0];
  assign push = do_make && lut_ascii != NUL;
  assign pop = !empty && ascii_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop);
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wptr[AW-1:0]] <= lut_ascii;
        wptr <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      if (push && !push_ok) overflow <= 1'b1;
    end
  end
  assign ascii_valid = !empty;
  assign ascii_out = empty ? NUL : mem[rptr[AW-1:0]];
endmodule
